// File: rtl/chacha_ctrl.sv
// Sequencer between host shadow registers and the chacha keystream core: replays key/nonce/counter
// bursts, waits for the core, drains 64 keystream bytes. Optional counter auto-increment: CHACHA_CTRL_AUTOINC_EN.
module chacha_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [5:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       blk_req,
    input  logic       pause,
    output logic       busy,
    output logic       ks_valid,
    output logic [7:0] ks_data,
    output logic       ks_last,
    output logic       cfg_err,
    output logic       ctr_wrap,
    output logic       core_wr_key,
    output logic       core_wr_nnc,
    output logic       core_wr_ctr,
    output logic       core_rd_blk,
    output logic       core_hold,
    output logic [7:0] core_data_in,
    input  logic       core_blk_ready,
    input  logic [7:0] core_data_out
);

    localparam int CNT_W = $clog2(RD_LAT + 66);
    localparam logic [CNT_W-1:0] KS_FIRST = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] KS_LAST  = CNT_W'(63 + RD_LAT);
    localparam logic [CNT_W-1:0] RD_END   = CNT_W'(64 + RD_LAT);

    typedef enum logic [2:0] {
        IDLE,
        LD_KEY,
        LD_NNC,
        LD_CTR,
        WAIT_RDY,
        READ
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       shadow_reg [48];   // 0-31 key, 32-39 nonce, 40-47 counter (LSB first)
    logic             key_dirty_reg, nnc_dirty_reg, cfg_err_reg;
    logic             ks_valid_reg, ks_last_reg;
    logic [7:0]       ks_data_reg;
    logic             in_burst;
    logic [5:0]       rd_idx;
    logic             blk_done;
    logic             cfg_ok;

    assign blk_done = (state_reg == READ) && (cnt_reg == RD_END);
    assign cfg_ok   = cfg_we && (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        in_burst    = 1'b0;
        rd_idx      = 6'd0;
        core_wr_key = 1'b0;
        core_wr_nnc = 1'b0;
        core_wr_ctr = 1'b0;
        core_rd_blk = 1'b0;
        core_hold   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (blk_req) begin
                    if (key_dirty_reg)      state_next = LD_KEY;
                    else if (nnc_dirty_reg) state_next = LD_NNC;
                    else                    state_next = LD_CTR;
                end
            end
            LD_KEY: begin
                in_burst    = 1'b1;
                rd_idx      = {1'b0, cnt_reg[4:0]};
                core_wr_key = (cnt_reg == '0);
                if (cnt_reg == CNT_W'(31)) begin
                    state_next = nnc_dirty_reg ? LD_NNC : LD_CTR;
                    cnt_next   = '0;
                end
            end
            LD_NNC: begin
                in_burst    = 1'b1;
                rd_idx      = 6'd32 + {3'b000, cnt_reg[2:0]};
                core_wr_nnc = (cnt_reg == '0);
                if (cnt_reg == CNT_W'(7)) begin
                    state_next = LD_CTR;
                    cnt_next   = '0;
                end
            end
            LD_CTR: begin
                in_burst    = 1'b1;
                rd_idx      = 6'd40 + {3'b000, cnt_reg[2:0]};
                core_wr_ctr = (cnt_reg == '0);
                if (cnt_reg == CNT_W'(7)) begin
                    state_next = WAIT_RDY;
                    cnt_next   = '0;
                end
            end
            WAIT_RDY: begin
                cnt_next  = '0;
                core_hold = pause;
                if (core_blk_ready) state_next = READ;
            end
            READ: begin
                core_rd_blk = (cnt_reg == '0);
                if (blk_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign core_data_in = in_burst ? shadow_reg[rd_idx] : 8'h00;

`ifdef CHACHA_CTRL_AUTOINC_EN
    logic [63:0] ctr_val;
    logic [63:0] ctr_inc;
    logic        ctr_wrap_reg;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_ctr_pack
        assign ctr_val[8*gi +: 8] = shadow_reg[40 + gi];
    end
    assign ctr_inc = ctr_val + 64'd1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ctr_wrap_reg <= 1'b0;
        else if (blk_done && (&ctr_val))
            ctr_wrap_reg <= 1'b1;
    end
    assign ctr_wrap = ctr_wrap_reg;
`else
    assign ctr_wrap = 1'b0;
`endif

    // Host writes only land in IDLE, so they never collide with the end-of-block counter update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 48; i++) shadow_reg[i] <= 8'h00;
        end else begin
            if (cfg_ok && (cfg_addr < 6'd48)) shadow_reg[cfg_addr] <= cfg_wdata;
`ifdef CHACHA_CTRL_AUTOINC_EN
            if (blk_done) begin
                for (int i = 0; i < 8; i++) shadow_reg[40 + i] <= ctr_inc[8*i +: 8];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_dirty_reg <= 1'b1;
            nnc_dirty_reg <= 1'b1;
            cfg_err_reg   <= 1'b0;
            ks_valid_reg  <= 1'b0;
            ks_last_reg   <= 1'b0;
            ks_data_reg   <= 8'h00;
        end else begin
            if (cfg_we && (state_reg != IDLE)) cfg_err_reg <= 1'b1;
            if (cfg_ok && (cfg_addr < 6'd32)) key_dirty_reg <= 1'b1;
            else if (state_reg == LD_KEY && cnt_reg == CNT_W'(31)) key_dirty_reg <= 1'b0;
            if (cfg_ok && (cfg_addr >= 6'd32) && (cfg_addr < 6'd40)) nnc_dirty_reg <= 1'b1;
            else if (state_reg == LD_NNC && cnt_reg == CNT_W'(7)) nnc_dirty_reg <= 1'b0;
            // Byte i leaves the core RD_LAT cycles after T0+i; capture it one edge later.
            if (state_reg == READ && cnt_reg >= KS_FIRST && cnt_reg <= KS_LAST) begin
                ks_valid_reg <= 1'b1;
                ks_data_reg  <= core_data_out;
            end else begin
                ks_valid_reg <= 1'b0;
                ks_data_reg  <= 8'h00;
            end
            ks_last_reg <= (state_reg == READ) && (cnt_reg == KS_LAST);
        end
    end

    assign busy     = (state_reg != IDLE);
    assign ks_valid = ks_valid_reg;
    assign ks_data  = ks_data_reg;
    assign ks_last  = ks_last_reg;
    assign cfg_err  = cfg_err_reg;

endmodule

// File: tb/tb_chacha_ctrl.sv
// Directed bench for chacha_ctrl with a small core model (blk_ready after a delay, patterned block bytes).
module tb_chacha_ctrl;

`ifdef CHACHA_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, blk_req, pause;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       busy, ks_valid, ks_last, cfg_err, ctr_wrap;
    logic [7:0] ks_data, core_data_in, core_data_out;
    logic       core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold;
    logic       core_blk_ready;

    always #5 clk = ~clk;

    chacha_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .blk_req(blk_req), .pause(pause), .busy(busy), .ks_valid(ks_valid), .ks_data(ks_data),
        .ks_last(ks_last), .cfg_err(cfg_err), .ctr_wrap(ctr_wrap), .core_wr_key(core_wr_key),
        .core_wr_nnc(core_wr_nnc), .core_wr_ctr(core_wr_ctr), .core_rd_blk(core_rd_blk),
        .core_hold(core_hold), .core_data_in(core_data_in), .core_blk_ready(core_blk_ready),
        .core_data_out(core_data_out)
    );

    // Core model: blk_ready pulses 9+rdy_wait cycles after the counter strobe; block bytes follow rd_blk by one cycle.
    logic [7:0] seed;
    int         rdy_wait;
    int         ctr_cd;
    logic       rd_act;
    logic [5:0] rd_pos;

    always @(posedge clk) begin
        if (!rst_n) begin
            ctr_cd         <= 0;
            core_blk_ready <= 1'b0;
            rd_act         <= 1'b0;
            rd_pos         <= 6'd0;
        end else begin
            core_blk_ready <= (ctr_cd == 1);
            if (core_wr_ctr) ctr_cd <= 8 + rdy_wait;
            else if (ctr_cd != 0) ctr_cd <= ctr_cd - 1;
            if (core_rd_blk) begin
                rd_act <= 1'b1;
                rd_pos <= 6'd0;
            end else if (rd_act) begin
                rd_pos <= rd_pos + 6'd1;
                if (rd_pos == 6'd63) rd_act <= 1'b0;
            end
        end
    end
    assign core_data_out = rd_act ? (({2'b00, rd_pos} * 8'd7) ^ seed) : 8'h00;

    function automatic logic [7:0] ks_exp(input int i);
        logic [7:0] b;
        b = 8'(i * 7);
        return b ^ seed;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-block observation log, filled by step()
    int           cyc = 0;
    int           req_cyc, key_n, nnc_n, ctr_n, key_cyc, nnc_cyc, ctr_cyc;
    int           burst_kind, burst_pos, rd_n, rd_cyc, ks_n, ks_bad, first_cyc;
    int           last_n, last_idx, last_cyc, fall_cyc, hold_total, hold_bad;
    logic [255:0] key_bytes;
    logic [63:0]  nnc_bytes, ctr_bytes;
    logic [63:0]  exp_ctr;

    task automatic clear_log();
        key_n = 0; nnc_n = 0; ctr_n = 0; key_cyc = -1; nnc_cyc = -1; ctr_cyc = -1;
        burst_kind = 0; burst_pos = 0; rd_n = 0; rd_cyc = -1; ks_n = 0; ks_bad = 0;
        first_cyc = -1; last_n = 0; last_idx = -1; last_cyc = -1; fall_cyc = -1;
        hold_total = 0; hold_bad = 0;
        key_bytes = '1; nnc_bytes = '1; ctr_bytes = '1;
    endtask

    task automatic step();
        bit in_burst;
        @(negedge clk);
        cyc++;
        in_burst = (burst_kind != 0) || core_wr_key || core_wr_nnc || core_wr_ctr;
        if (core_wr_key) begin key_n++; key_cyc = cyc; burst_kind = 1; burst_pos = 0; end
        if (core_wr_nnc) begin nnc_n++; nnc_cyc = cyc; burst_kind = 2; burst_pos = 0; end
        if (core_wr_ctr) begin ctr_n++; ctr_cyc = cyc; burst_kind = 3; burst_pos = 0; end
        if (core_hold) begin
            hold_total++;
            if (in_burst) hold_bad++;
        end
        if (burst_kind == 1) key_bytes[8*burst_pos +: 8] = core_data_in;
        if (burst_kind == 2) nnc_bytes[8*burst_pos +: 8] = core_data_in;
        if (burst_kind == 3) ctr_bytes[8*burst_pos +: 8] = core_data_in;
        if (burst_kind != 0) begin
            burst_pos++;
            if (burst_pos == ((burst_kind == 1) ? 32 : 8)) burst_kind = 0;
        end
        if (core_rd_blk) begin rd_n++; rd_cyc = cyc; end
        if (ks_valid) begin
            if (ks_data !== ks_exp(ks_n)) ks_bad++;
            if (ks_n == 0) first_cyc = cyc;
            if (ks_last) begin last_n++; last_idx = ks_n; last_cyc = cyc; end
            ks_n++;
        end else if (ks_last) begin
            last_n++;
        end
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    // One block request; optional dropped write in cycle R+wr_at, optional reset after byte 20.
    task automatic run_block(input int wr_at, input bit rst20);
        bit done;
        int guard;
        clear_log();
        done = 1'b0;
        guard = 0;
        cfg_addr = 6'd40; cfg_wdata = 8'h55;
        blk_req = 1'b1;
        req_cyc = cyc;
        step();
        blk_req = 1'b0;
        while (!done && guard < 400) begin
            cfg_we = (cyc - req_cyc == wr_at);
            step();
            guard++;
            if (rst20 && ks_n == 21) begin
                cfg_we = 1'b0;
                rst_n = 1'b0;
                step();
                check("rst_ks_valid", 256'(ks_valid), 256'(0));
                check("rst_busy", 256'(busy), 256'(0));
                check("rst_cfg_err", 256'(cfg_err), 256'(0));
                check("rst_ctr_wrap", 256'(ctr_wrap), 256'(0));
                rst_n = 1'b1;
                done = 1'b1;
            end else if (!busy) begin
                fall_cyc = cyc;
                done = 1'b1;
            end
        end
        cfg_we = 1'b0;
        if (!done) check("block_timeout", 256'(busy), 256'(0));
    endtask

    // Checks common to every completed block; pre = burst cycles before the counter burst.
    task automatic check_block(input int pre);
        $display("block req@%0d key=%0d nnc=%0d ctr=%0h ks=%0d last_idx=%0d", req_cyc, key_n, nnc_n, ctr_bytes, ks_n, last_idx);
        check("ctr_strobes", 256'(ctr_n), 256'(1));
        check("ctr_bytes", 256'(ctr_bytes), 256'(exp_ctr));
        check("ctr_cycle", 256'(ctr_cyc), 256'(req_cyc + 1 + pre));
        check("rd_strobes", 256'(rd_n), 256'(1));
        check("rd_cycle", 256'(rd_cyc), 256'(ctr_cyc + 10 + rdy_wait));
        check("ks_first_cycle", 256'(first_cyc), 256'(rd_cyc + 2));
        check("ks_count", 256'(ks_n), 256'(64));
        check("ks_data_bad", 256'(ks_bad), 256'(0));
        check("ks_last_count", 256'(last_n), 256'(1));
        check("ks_last_idx", 256'(last_idx), 256'(63));
        check("ks_last_cycle", 256'(last_cyc), 256'(rd_cyc + 65));
        check("busy_fall", 256'(fall_cyc), 256'(last_cyc + 1));
        if (AUTOINC) exp_ctr = exp_ctr + 64'd1;
    endtask

    logic [255:0] exp_key;

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 6'd0; cfg_wdata = 8'h00;
        blk_req = 1'b0; pause = 1'b0; seed = 8'h00; rdy_wait = 2;
        clear_log();
        step(); step(); step();
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_outputs", 256'({ks_valid, ks_last, ks_data, cfg_err, ctr_wrap}), 256'(0));
        check("reset_core_if", 256'({core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk, core_hold, core_data_in}), 256'(0));
        rst_n = 1'b1;
        step();

        // Block 1: full parameter load
        for (int i = 0; i < 32; i++) begin
            cfg_write(6'(i), 8'(i));
            exp_key[8*i +: 8] = 8'(i);
        end
        for (int i = 0; i < 8; i++) cfg_write(6'(32 + i), 8'(i));
        cfg_write(6'd40, 8'h01);
        for (int i = 1; i < 8; i++) cfg_write(6'(40 + i), 8'h00);
        exp_ctr = 64'd1;
        seed = 8'h3C;
        run_block(-1, 1'b0);
        check("b1_key_strobes", 256'(key_n), 256'(1));
        check("b1_key_cycle", 256'(key_cyc), 256'(req_cyc + 1));
        check("b1_key_bytes", key_bytes, exp_key);
        check("b1_nnc_strobes", 256'(nnc_n), 256'(1));
        check("b1_nnc_cycle", 256'(nnc_cyc), 256'(req_cyc + 33));
        check("b1_nnc_bytes", 256'(nnc_bytes), 256'(64'h0706050403020100));
        check("b1_hold", 256'(hold_total), 256'(0));
        check_block(40);

        // Block 2: clean parameters, only the counter burst
        step();
        seed = 8'h5A;
        run_block(-1, 1'b0);
        check("b2_key_strobes", 256'(key_n), 256'(0));
        check("b2_nnc_strobes", 256'(nnc_n), 256'(0));
        check_block(0);

        // Block 3: pause held high; only WAIT_RDY cycles forward it
        step();
        pause = 1'b1; rdy_wait = 4; seed = 8'hC3;
        run_block(-1, 1'b0);
        pause = 1'b0;
        check("b3_hold_in_burst", 256'(hold_bad), 256'(0));
        check("b3_hold_cycles", 256'(hold_total), 256'(rdy_wait + 2));
        check_block(0);

        // Block 4: a write during WAIT_RDY is dropped and flagged
        step();
        check("b4_cfg_err_before", 256'(cfg_err), 256'(0));
        rdy_wait = 6; seed = 8'h96;
        run_block(12, 1'b0);
        check_block(0);
        check("b4_cfg_err", 256'(cfg_err), 256'(1));

        // Block 5: counter shows the dropped write never landed
        step();
        rdy_wait = 2; seed = 8'h0F;
        run_block(-1, 1'b0);
        check_block(0);
        check("b5_cfg_err_sticky", 256'(cfg_err), 256'(1));

        // Blocks 6/7: counter at all-ones
        for (int i = 0; i < 8; i++) cfg_write(6'(40 + i), 8'hFF);
        exp_ctr = '1;
        check("b6_wrap_before", 256'(ctr_wrap), 256'(0));
        seed = 8'hE1;
        run_block(-1, 1'b0);
        check_block(0);
        check("b6_ctr_wrap", 256'(ctr_wrap), 256'(AUTOINC));
        step();
        seed = 8'h77;
        run_block(-1, 1'b0);
        check_block(0);

        // Block 8: reset during the read; block 9 must reload everything from zeroed shadows
        step();
        seed = 8'h24;
        run_block(-1, 1'b1);
        check("b8_bytes_before_reset", 256'(ks_n), 256'(21));
        step();
        exp_ctr = 64'd0;
        seed = 8'hB8;
        run_block(-1, 1'b0);
        check("b9_key_strobes", 256'(key_n), 256'(1));
        check("b9_key_cycle", 256'(key_cyc), 256'(req_cyc + 1));
        check("b9_key_bytes", key_bytes, 256'(0));
        check("b9_nnc_strobes", 256'(nnc_n), 256'(1));
        check("b9_nnc_bytes", 256'(nnc_bytes), 256'(0));
        check_block(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_ctrl.md
# chacha_ctrl

Sequencer between the host register interface and the `chacha` keystream core. Holds shadow copies of key, nonce and block counter. On each block request it replays the dirty parameters into the core as contiguous byte bursts, waits for the core's `blk_ready`, then drains the 64-byte block onto a keystream byte output. It advances the counter after each block.

## Interface
Parameters:
- `RD_LAT`, 1: cycles from a core read address being issued to its byte on `core_data_out`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_we` in 1: shadow register write strobe.
- `cfg_addr` in 6: byte address. 0x00-0x1F key, 0x20-0x27 nonce, 0x28-0x2F counter (LSB first); 0x30-0x3F ignored.
- `cfg_wdata` in 8: write byte.
- `blk_req` in 1: level; request a keystream block.
- `pause` in 1: forwarded to `core_hold` while waiting on the core.
- `busy` out 1: high in every state except IDLE.
- `ks_valid` out 1: keystream byte valid.
- `ks_data` out 8: keystream byte.
- `ks_last` out 1: with the 64th byte.
- `cfg_err` out 1: sticky; a write was dropped while busy.
- `ctr_wrap` out 1: sticky; counter wrapped 2^64-1 -> 0.
- `core_wr_key`, `core_wr_nnc`, `core_wr_ctr`, `core_rd_blk`, `core_hold` out 1: core controls.
- `core_data_in` out 8: core write bus.
- `core_blk_ready` in 1: from core.
- `core_data_out` in 8: from core.

## Operation
- Shadow registers: key 256b, nonce 64b, counter 64b. `key_dirty` and `nnc_dirty` are set by any write into their range and cleared when the matching burst completes. A counter write does not set a flag; the counter is always sent.
- `cfg_we` in IDLE: write takes effect at the clock edge.
- `cfg_we` in any other state: write dropped, `cfg_err` set (cleared only by reset).
- States are IDLE, LD_KEY, LD_NNC, LD_CTR, WAIT_RDY and READ.
- IDLE with `blk_req`=1: next state is LD_KEY if `key_dirty`, else LD_NNC if `nnc_dirty`, else LD_CTR.
- LD_x: 32/8/8 consecutive cycles. `core_wr_x`=1 in the first cycle only. `core_data_in` = shadow byte n in burst cycle n, byte 0 first. There are no idle cycles inside a burst.
- Burst order: LD_KEY -> LD_NNC (if dirty) or LD_CTR; LD_NNC -> LD_CTR; LD_CTR -> WAIT_RDY.
- WAIT_RDY: `core_hold` = `pause`. Leaves on the cycle after `core_blk_ready` is sampled high.
- READ: `core_rd_blk`=1 in the first cycle (T0). Lasts 64+RD_LAT+1 cycles.
  - Keystream: `ks_data`/`ks_valid` are registered copies of `core_data_out`. Byte i appears at T0+i+RD_LAT+1.
  - Block end: `ks_last` accompanies i=63. At that edge the state returns to IDLE and the counter update rule (Configuration) applies.
- `blk_req` still high in IDLE starts the next block the following cycle. Key and nonce are not re-sent unless rewritten.
- `core_data_in`=0 and all core strobes are 0 outside LD/READ.

## Timing
- Reset values:
  - State IDLE; all outputs 0; `cfg_err`=0, `ctr_wrap`=0.
  - Shadow registers 0; `key_dirty`=`nnc_dirty`=1.
- Request latency: `blk_req` sampled at cycle R gives the first burst cycle R+1.
- Clean-parameter block: LD_CTR R+1..R+8, WAIT_RDY from R+9, then READ.
- Reset mid-burst or mid-read: abort immediately and return to reset values. Partial keystream is not flagged. The host must rewrite parameters; the dirty flags force a full reload.
- `pause` has no effect outside WAIT_RDY.
- `blk_req` dropped mid-block: the current block completes.

## Configuration
- `CHACHA_CTRL_AUTOINC_EN` defined:
  - Counter increments by 1 at the `ks_last` edge.
  - All-ones increments to 0 and sets `ctr_wrap`.
- Undefined:
  - Counter is held; every block reuses the host-written counter.
  - `ctr_wrap` is tied 0.

## Test plan
- Reset, write key bytes 0x00..0x1F, nonce 0x00..0x07, counter 1, pulse `blk_req` -> `core_wr_key` high once, then 32 consecutive key bytes, then 8 nonce bytes with one `core_wr_nnc`, then 8 counter bytes `01 00 .. 00`. A model `blk_ready`/`data_out` yields 64 `ks_valid` bytes, `ks_last` on the 64th.
- Second `blk_req` with no writes -> only the LD_CTR burst, carrying `02 00..00` (AUTOINC_EN) or `01 00..00` (without).
- Counter = 0xFFFFFFFFFFFFFFFF, one block, AUTOINC_EN -> next burst `00`x8, `ctr_wrap`=1.
- `cfg_we` during WAIT_RDY -> shadow unchanged, `cfg_err`=1 until reset.
- `pause`=1 in WAIT_RDY -> `core_hold`=1.
- `pause`=1 in LD_CTR -> `core_hold`=0.
- `rst_n` low at read byte 20 -> next cycle `ks_valid`=0, `busy`=0. Next `blk_req` starts with LD_KEY.
